// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared FSM state type and requantisation helper for the CIM output buffer
package cim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } obuf_state_t;

    localparam int REQUANT_W = 64;

    // Arithmetic shift then clamp into the unsigned range [0, 2^data_size-1].
    function automatic logic [REQUANT_W-1:0] requant(
        input logic signed [REQUANT_W-1:0] x,
        input int                          shift,
        input int                          data_size
    );
        logic signed [REQUANT_W-1:0] y;
        logic signed [REQUANT_W-1:0] max_v;
        y     = x >>> shift;
        max_v = $signed((REQUANT_W'(1) << data_size) - REQUANT_W'(1));
        if (y[REQUANT_W-1]) begin
            requant = '0;
        end else if (y > max_v) begin
            requant = max_v;
        end else begin
            requant = y;
        end
    endfunction

endpackage

// File: rtl/fc_obuf.sv
// rtl/fc_obuf.sv - FC output buffer: bit-plane shift-accumulate, then requantised drain one neuron per cycle
module fc_obuf
    import cim_pkg::*;
#(
    parameter  int DATA_SIZE      = 8,
    parameter  int OUTPUT_NEURONS = 10,
    parameter  int PSUM_WIDTH     = 16,
    parameter  int NUM_ADDR       = 4,
    parameter  int OUT_SHIFT      = 8,
    localparam int COUNT_WIDTH    = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE),
    localparam int ACC_WIDTH      = PSUM_WIDTH + DATA_SIZE + $clog2(NUM_ADDR) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_psum_valid,
    input  logic signed [PSUM_WIDTH-1:0] i_psum [OUTPUT_NEURONS],
    input  logic [COUNT_WIDTH-1:0]       i_count,
    input  logic                         i_last,
    output logic                         o_busy,
    output logic                         o_write_enable,
    output logic [DATA_SIZE-1:0]         o_data,
    output logic                         o_overrun
);

    localparam int               IDX_W    = (OUTPUT_NEURONS > 1) ? $clog2(OUTPUT_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NEURONS - 1);

    obuf_state_t                 state;
    obuf_state_t                 state_next;
    logic [IDX_W-1:0]            idx;
    logic signed [ACC_WIDTH-1:0] acc    [OUTPUT_NEURONS];
    logic signed [ACC_WIDTH-1:0] addend [OUTPUT_NEURONS];
    logic                        accept;
    logic                        drain_done;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (i_psum_valid) begin
                    accept     = 1'b1;
                    state_next = i_last ? DRAIN : ACCUM;
                end
            end
            DRAIN: begin
                if (idx == LAST_IDX) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit-plane weighting: sign-extend to the accumulator width, then shift by plane index.
    always_comb begin
        for (int n = 0; n < OUTPUT_NEURONS; n++) begin
            addend[n] = ACC_WIDTH'(i_psum[n]) <<< i_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || drain_done) begin
            for (int n = 0; n < OUTPUT_NEURONS; n++) begin
                acc[n] <= '0;
            end
        end else if (accept) begin
            for (int n = 0; n < OUTPUT_NEURONS; n++) begin
                acc[n] <= acc[n] + addend[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            o_write_enable <= 1'b0;
            o_data         <= '0;
            o_overrun      <= 1'b0;
        end else begin
            o_write_enable <= 1'b0;
            o_overrun      <= i_psum_valid && (state == DRAIN);
            if (state == DRAIN) begin
                o_write_enable <= 1'b1;
                o_data         <= DATA_SIZE'(requant(REQUANT_W'(acc[idx]), OUT_SHIFT, DATA_SIZE));
                idx            <= drain_done ? '0 : idx + 1'b1;
            end
        end
    end

    assign o_busy = (state == DRAIN);

endmodule

// File: tb/tb_fc_obuf.sv
// tb/tb_fc_obuf.sv - self-checking bench for fc_obuf with a reference accumulate/requant model
module tb_fc_obuf;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid = 1'b0;
    logic               last = 1'b0;
    logic [2:0]         count = 3'd0;
    logic signed [15:0] psum [N];
    logic               busy0, we0, ovr0, busy8, we8, ovr8;
    logic [7:0]         data0, data8;

    int checks = 0;
    int errors = 0;
    int ovr_pulses = 0;
    int busy_cyc = 0;

    longint     macc [N];
    logic [7:0] exp0 [$];
    logic [7:0] exp8 [$];
    logic [7:0] got0 [$];
    logic [7:0] got8 [$];

    always #5 clk = ~clk;

    fc_obuf #(.DATA_SIZE(8), .OUTPUT_NEURONS(N), .PSUM_WIDTH(16), .NUM_ADDR(2), .OUT_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .i_psum_valid(valid), .i_psum(psum), .i_count(count), .i_last(last),
        .o_busy(busy0), .o_write_enable(we0), .o_data(data0), .o_overrun(ovr0)
    );

    fc_obuf #(.DATA_SIZE(8), .OUTPUT_NEURONS(N), .PSUM_WIDTH(16), .NUM_ADDR(2), .OUT_SHIFT(8)) dut8 (
        .clk(clk), .rst(rst), .i_psum_valid(valid), .i_psum(psum), .i_count(count), .i_last(last),
        .o_busy(busy8), .o_write_enable(we8), .o_data(data8), .o_overrun(ovr8)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (we0) got0.push_back(data0);
            if (we8) got8.push_back(data8);
            if (ovr0) ovr_pulses++;
            if (busy0) busy_cyc++;
        end
    end

    function automatic logic [7:0] ref_requant(input longint x, input int sh);
        longint y;
        y = x >>> sh;
        if (y < 0) return 8'd0;
        if (y > 255) return 8'd255;
        return y[7:0];
    endfunction

    task automatic clear_model();
        for (int n = 0; n < N; n++) macc[n] = 0;
        exp0.delete(); exp8.delete(); got0.delete(); got8.delete();
    endtask

    // Presents one vector for one cycle; the model only counts it when the caller says it is accepted.
    task automatic drive(input int v0, input int v1, input int v2, input int v3,
                         input int cnt, input bit lst, input bit accept);
        int v [N];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int n = 0; n < N; n++) psum[n] = 16'(v[n]);
        count = 3'(cnt);
        last  = lst;
        valid = 1'b1;
        if (accept) begin
            for (int n = 0; n < N; n++) macc[n] += longint'(v[n]) * (longint'(1) << cnt);
            if (lst) begin
                for (int n = 0; n < N; n++) begin
                    exp0.push_back(ref_requant(macc[n], 0));
                    exp8.push_back(ref_requant(macc[n], 8));
                    macc[n] = 0;
                end
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy0 && !we0 && got0.size() == exp0.size()) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int n = 0; n < N; n++) psum[n] = 16'sd50;
        rst = 1'b1; valid = 1'b1; last = 1'b1;
        repeat (2) @(posedge clk);
        #1 valid = 1'b0; last = 1'b0;
        @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy0); end
        checks++; if (we0 !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", we0); end
        checks++; if (data0 !== 8'd0) begin errors++; $display("FAIL reset_data got=%0d want=0", data0); end
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", ovr0); end
        checks++; if (we8 !== 1'b0 || data8 !== 8'd0) begin errors++; $display("FAIL reset_dut8 got we=%b data=%0d want 0/0", we8, data8); end
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_ones();
        bit ok;
        int b0;
        b0 = busy_cyc;
        for (int c = 0; c < 8; c++) drive(1, 1, 1, 1, c, c == 7, 1'b1);
        @(negedge clk);
        checks++; if (busy0 !== 1'b1 || we0 !== 1'b0) begin errors++; $display("FAIL lat_t1 got busy=%b we=%b want 1/0", busy0, we0); end
        @(negedge clk);
        checks++; if (we0 !== 1'b1 || data0 !== exp0[0]) begin errors++; $display("FAIL lat_t2 got we=%b data=%0d want 1/%0d", we0, data0, exp0[0]); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ones_timeout got=%0d want=%0d strobes", got0.size(), exp0.size()); end
        checks++; if (busy_cyc - b0 !== N) begin errors++; $display("FAIL ones_busy_cycles got=%0d want=%0d", busy_cyc - b0, N); end
        checks++; if (data0 !== exp0[N-1]) begin errors++; $display("FAIL ones_data_hold got=%0d want=%0d", data0, exp0[N-1]); end
        for (int i = 0; i < N; i++) begin
            checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL ones_data0[%0d] got=%0d want=%0d", i, got0[i], exp0[i]); end
            checks++; if (got8[i] !== exp8[i]) begin errors++; $display("FAIL ones_data8[%0d] got=%0d want=%0d", i, got8[i], exp8[i]); end
        end
        clear_model();
    endtask

    task automatic test_single();
        bit ok;
        drive(-5, 300, 7, 0, 0, 1'b1, 1'b1);
        wait_idle(ok);
        checks++; if (!ok || got0.size() != N) begin errors++; $display("FAIL single_count got=%0d want=%0d", got0.size(), N); end
        for (int i = 0; i < N; i++) begin
            checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL single_data0[%0d] got=%0d want=%0d", i, got0[i], exp0[i]); end
            checks++; if (got8[i] !== exp8[i]) begin errors++; $display("FAIL single_data8[%0d] got=%0d want=%0d", i, got8[i], exp8[i]); end
        end
        clear_model();
    endtask

    task automatic test_same_count();
        bit ok;
        drive(3, 3, 3, 3, 2, 1'b0, 1'b1);
        drive(3, 3, 3, 3, 2, 1'b1, 1'b1);
        wait_idle(ok);
        checks++; if (!ok || got0.size() != N) begin errors++; $display("FAIL samecnt_count got=%0d want=%0d", got0.size(), N); end
        for (int i = 0; i < N; i++) begin
            checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL samecnt_data0[%0d] got=%0d want=%0d", i, got0[i], exp0[i]); end
        end
        clear_model();
    endtask

    task automatic test_overrun();
        bit ok;
        int p0;
        p0 = ovr_pulses;
        drive(1, 2, 3, 4, 0, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(100, 100, 100, 100, 5, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL overrun_pulse got=%b want=1", ovr0); end
        @(negedge clk);
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL overrun_width got=%b want=0", ovr0); end
        wait_idle(ok);
        checks++; if (ovr_pulses - p0 !== 1) begin errors++; $display("FAIL overrun_total got=%0d want=1", ovr_pulses - p0); end
        checks++; if (!ok || got0.size() != N) begin errors++; $display("FAIL overrun_count got=%0d want=%0d", got0.size(), N); end
        for (int i = 0; i < N; i++) begin
            checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL overrun_data0[%0d] got=%0d want=%0d", i, got0[i], exp0[i]); end
        end
        clear_model();
        drive(5, 6, 7, 8, 0, 1'b1, 1'b1);
        wait_idle(ok);
        for (int i = 0; i < N; i++) begin
            checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL overrun_next0[%0d] got=%0d want=%0d", i, got0[i], exp0[i]); end
        end
        clear_model();
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        drive(20, 20, 20, 20, 0, 1'b1, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL rstmid_third_strobe got=%b want=1", we0); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (we0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_stop got we=%b busy=%b want 0/0", we0, busy0); end
        checks++; if (data0 !== 8'd0) begin errors++; $display("FAIL rstmid_data got=%0d want=0", data0); end
        clear_model();
        drive(9, 9, 9, 9, 0, 1'b1, 1'b1);
        wait_idle(ok);
        checks++; if (!ok || got0.size() != N) begin errors++; $display("FAIL rstmid_count got=%0d want=%0d", got0.size(), N); end
        for (int i = 0; i < N; i++) begin
            checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL rstmid_data0[%0d] got=%0d want=%0d", i, got0[i], exp0[i]); end
        end
        clear_model();
    endtask

    task automatic test_shift8();
        bit ok;
        drive(1024, 1024, 1024, 1024, 1, 1'b1, 1'b1);
        wait_idle(ok);
        checks++; if (!ok || got8.size() != N) begin errors++; $display("FAIL shift8_count got=%0d want=%0d", got8.size(), N); end
        for (int i = 0; i < N; i++) begin
            checks++; if (got8[i] !== exp8[i]) begin errors++; $display("FAIL shift8_data8[%0d] got=%0d want=%0d", i, got8[i], exp8[i]); end
            checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL shift8_data0[%0d] got=%0d want=%0d", i, got0[i], exp0[i]); end
        end
        clear_model();
    endtask

    task automatic test_random();
        bit ok;
        int nv;
        for (int r = 0; r < 8; r++) begin
            nv = int'($urandom_range(1, 4));
            for (int k = 0; k < nv; k++) begin
                drive(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                      int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                      int'($urandom_range(0, 7)), k == nv - 1, 1'b1);
                if (k != nv - 1) begin
                    repeat ($urandom_range(0, 2)) begin
                        last = 1'b1;
                        @(posedge clk); #1;
                        last = 1'b0;
                    end
                end
            end
            wait_idle(ok);
            checks++; if (!ok || got0.size() != N) begin errors++; $display("FAIL rand%0d_count got=%0d want=%0d", r, got0.size(), N); end
            for (int i = 0; i < N; i++) begin
                checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL rand%0d_data0[%0d] got=%0d want=%0d", r, i, got0[i], exp0[i]); end
                checks++; if (got8[i] !== exp8[i]) begin errors++; $display("FAIL rand%0d_data8[%0d] got=%0d want=%0d", r, i, got8[i], exp8[i]); end
            end
            clear_model();
        end
    endtask

    initial begin
        for (int n = 0; n < N; n++) psum[n] = '0;
        test_reset();
        test_ones();
        test_single();
        test_same_count();
        test_overrun();
        test_reset_mid_drain();
        test_shift8();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule

// File: doc/fc_obuf.md
FC_OBUF -- requirements
Module: fc_obuf

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, meaning output activation width and number of input bit-planes.
REQ-002 The block SHALL have parameter OUTPUT_NEURONS, default 10, meaning number of FC outputs produced per inference.
REQ-003 The block SHALL have parameter PSUM_WIDTH, default 16, meaning width of the signed per-neuron crossbar partial sum.
REQ-004 The block SHALL have parameter NUM_ADDR, default 4, meaning input-buffer words summed per bit-plane.
REQ-005 The block SHALL have parameter OUT_SHIFT, default 8, meaning arithmetic right shift applied before requantisation.
REQ-006 The block SHALL have derived parameters COUNT_WIDTH = (DATA_SIZE==1) ? 1 : clog2(DATA_SIZE) and ACC_WIDTH = PSUM_WIDTH+DATA_SIZE+clog2(NUM_ADDR)+1.
REQ-007 Port list: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-008 Port list: i_psum_valid input 1, partial-sum vector valid this cycle.
REQ-009 Port list: i_psum input signed PSUM_WIDTH x OUTPUT_NEURONS unpacked array, one partial sum per neuron.
REQ-010 Port list: i_count input COUNT_WIDTH, bit-plane index of this partial-sum vector.
REQ-011 Port list: i_last input 1, qualifies final vector of the inference.
REQ-012 Port list: o_busy output 1, high while draining.
REQ-013 Port list: o_write_enable output 1, one-cycle write strobe to the next layer's input buffer.
REQ-014 Port list: o_data output DATA_SIZE, unsigned activation.
REQ-015 Port list: o_overrun output 1, one-cycle pulse when a vector is dropped.

Function
REQ-016 The block SHALL implement FSM states IDLE, ACCUM, DRAIN.
REQ-017 In IDLE or ACCUM, each i_psum_valid cycle SHALL update acc[n] += sign_extend(i_psum[n]) << i_count for every n, in ACC_WIDTH two's complement, no wrap for legal inputs.
REQ-018 Transitions: IDLE->ACCUM on valid without i_last; IDLE or ACCUM -> DRAIN on valid with i_last; the i_last vector itself SHALL be accumulated.
REQ-019 In DRAIN, a neuron index SHALL advance 0..OUTPUT_NEURONS-1, one per cycle; for each index the registered outputs SHALL load o_write_enable=1 and o_data=requant(acc[index]).
REQ-020 requant(x) SHALL be: y = x >>> OUT_SHIFT; if y<0 then 0; else if y>2^DATA_SIZE-1 then 2^DATA_SIZE-1; else y.
REQ-021 After the index OUTPUT_NEURONS-1 cycle, all accumulators SHALL clear, the index SHALL reset to 0, and the state SHALL return to IDLE.
REQ-022 Latency: last vector accepted in cycle t -> o_busy high cycles t+1..t+OUTPUT_NEURONS -> o_write_enable high cycles t+2..t+OUTPUT_NEURONS+1, neuron 0 first.
REQ-023 o_busy SHALL equal (state==DRAIN).
REQ-024 o_write_enable SHALL be low in every cycle not listed in REQ-022.
REQ-025 o_data SHALL hold its last value when o_write_enable is low.
REQ-026 i_psum_valid while in DRAIN SHALL be dropped without changing any accumulator, with o_overrun high the following cycle.
REQ-027 i_last without i_psum_valid SHALL be ignored.
REQ-028 Repeated vectors with the same i_count (different addresses) SHALL each accumulate.

Reset
REQ-029 rst SHALL, at the next clk edge and from any state including mid-DRAIN, set state IDLE, neuron index 0, all acc 0, o_write_enable 0, o_data 0, o_overrun 0.
REQ-030 rst SHALL take priority over i_psum_valid in the same cycle.

Structure
REQ-031 The state enum and the requant saturation function SHALL live in the shared cim_pkg package.
REQ-032 The accumulator array and the FSM SHALL remain in fc_obuf; no sub-module is required.

Verification (OUTPUT_NEURONS=4, OUT_SHIFT=0, NUM_ADDR=1 unless stated)
REQ-033 Test: i_psum all 1 at counts 0..7, i_last with count 7 -> four strobes, o_data 255,255,255,255.
REQ-034 Test: single vector, count 0, psum {-5,300,7,0}, i_last -> o_data 0,255,7,0.
REQ-035 Test: NUM_ADDR=2, psum all 3 at count 2 twice, i_last on second -> o_data 24 x4.
REQ-036 Test: valid asserted in the 2nd DRAIN cycle -> o_overrun one-cycle pulse, drained values unchanged, next inference starts from zero.
REQ-037 Test: rst during the 3rd strobe -> o_write_enable 0 next cycle; a following count-0 psum 9 inference -> 9 x4.
REQ-038 Test: OUT_SHIFT=8, psum 1024 at count 1 -> o_data 8 x4.
